// File: rtl/cam_capture_pkg.sv
`default_nettype none
// cam_capture_pkg: shared FSM encoding, default geometry and counter helpers for the MT9D111 capture path.
// Revision 1.0
package cam_capture_pkg;

  typedef enum logic [1:0] {
    S_SKIP   = 2'd0,
    S_VBLANK = 2'd1,
    S_FRAME  = 2'd2
  } cap_state_e;

  // Same 800x600 geometry as the VGA output configuration.
  localparam int unsigned C_DEF_H_WIDTH  = 800;
  localparam int unsigned C_DEF_V_HEIGHT = 600;
  localparam logic [10:0] C_CNT_MAX      = 11'd2047;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == C_CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_byte_pair.sv
`default_nettype none
// dvp_byte_pair: registers the DVP bus, detects HREF/VSYNC edges and pairs bytes into 16-bit pixels.
// Revision 1.0
module dvp_byte_pair #(
  parameter int BYTE_SWAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_i,
  input  logic        href_i,
  input  logic [7:0]  d_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        half_pix_o,
  output logic        href_lvl_o,
  output logic        vs_rise_o,
  output logic        vs_fall_o
);

  logic        vsync_q, vsync_d, href_q, href_d;
  logic [7:0]  d_q, d_d, hold_q, hold_d;
  logic        vsync_prev_q, vsync_prev_d, href_prev_q, href_prev_d;
  logic        phase_q, phase_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        line_start_q, line_start_d, line_end_q, line_end_d;
  logic        half_pix_q, half_pix_d, href_lvl_q, href_lvl_d;
  logic        vs_rise_q, vs_rise_d, vs_fall_q, vs_fall_d;
  logic [15:0] pair;

  if (BYTE_SWAP != 0) begin : g_swap
    assign pair = {d_q, hold_q};
  end else begin : g_noswap
    assign pair = {hold_q, d_q};
  end

  always_comb begin
    vsync_d      = vsync_i;
    href_d       = href_i;
    d_d          = d_i;
    vsync_prev_d = vsync_q;
    href_prev_d  = href_q;
    hold_d       = hold_q;
    phase_d      = 1'b0;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    if (href_q) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hold_d = d_q;
      end else begin
        pix_valid_d = 1'b1;
        pix_data_d  = pair;
      end
    end
    line_start_d = href_q & ~href_prev_q;
    line_end_d   = ~href_q & href_prev_q;
    // phase still 1 at the falling edge means an unpaired byte is pending
    half_pix_d   = ~href_q & href_prev_q & phase_q;
    href_lvl_d   = href_q;
    vs_rise_d    = vsync_q & ~vsync_prev_q;
    vs_fall_d    = ~vsync_q & vsync_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'd0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      hold_q       <= 8'd0;
      phase_q      <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 16'd0;
      line_start_q <= 1'b0;
      line_end_q   <= 1'b0;
      half_pix_q   <= 1'b0;
      href_lvl_q   <= 1'b0;
      vs_rise_q    <= 1'b0;
      vs_fall_q    <= 1'b0;
    end else begin
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      d_q          <= d_d;
      vsync_prev_q <= vsync_prev_d;
      href_prev_q  <= href_prev_d;
      hold_q       <= hold_d;
      phase_q      <= phase_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      line_start_q <= line_start_d;
      line_end_q   <= line_end_d;
      half_pix_q   <= half_pix_d;
      href_lvl_q   <= href_lvl_d;
      vs_rise_q    <= vs_rise_d;
      vs_fall_q    <= vs_fall_d;
    end
  end

  assign pix_valid_o  = pix_valid_q;
  assign pix_data_o   = pix_data_q;
  assign line_start_o = line_start_q;
  assign line_end_o   = line_end_q;
  assign half_pix_o   = half_pix_q;
  assign href_lvl_o   = href_lvl_q;
  assign vs_rise_o    = vs_rise_q;
  assign vs_fall_o    = vs_fall_q;

endmodule
`default_nettype wire

// File: rtl/mt9d111_frame_capture.sv
`default_nettype none
// mt9d111_frame_capture: MT9D111 capture stage with settling-frame skip, window clipping and status.
// Revision 1.0
module mt9d111_frame_capture
  import cam_capture_pkg::*;
#(
  parameter int CAM_H_WIDTH  = C_DEF_H_WIDTH,
  parameter int CAM_V_HEIGHT = C_DEF_V_HEIGHT,
  parameter int SKIP_FRAMES  = 2,
  parameter int BYTE_SWAP    = 0
) (
  input  logic        MT9D111_CLK,
  input  logic        sys_rst_n,
  input  logic        MT9D111_VSYNC,
  input  logic        MT9D111_HREF,
  input  logic [7:0]  MT9D111_D,
  input  logic        err_clr,
  output logic [15:0] MT9D111_FrameData,
  output logic        MT9D111_FrameDataEn,
  output logic [10:0] MT9D111_FrameHCnt,
  output logic [10:0] MT9D111_FrameVCnt,
  output logic        MT9D111_FrameNewEn,
  output logic        cap_err,
  output logic [15:0] cap_frame_cnt,
  output logic [10:0] last_frame_lines
);

  localparam logic [10:0] H_LIM    = 11'(CAM_H_WIDTH);
  localparam logic [10:0] V_LIM    = 11'(CAM_V_HEIGHT);
  localparam logic [3:0]  SKIP_LIM = 4'(SKIP_FRAMES);

  logic        pix_valid, line_start, line_end, half_pix, href_lvl, vs_rise, vs_fall;
  logic [15:0] pix_data;

  dvp_byte_pair #(.BYTE_SWAP(BYTE_SWAP)) u_pair (
    .clk         (MT9D111_CLK),
    .rst_n       (sys_rst_n),
    .vsync_i     (MT9D111_VSYNC),
    .href_i      (MT9D111_HREF),
    .d_i         (MT9D111_D),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data),
    .line_start_o(line_start),
    .line_end_o  (line_end),
    .half_pix_o  (half_pix),
    .href_lvl_o  (href_lvl),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall)
  );

  cap_state_e  state_q, state_d;
  logic [3:0]  skip_cnt_q, skip_cnt_d;
  logic [10:0] vcnt_q, vcnt_d, hcnt_q, hcnt_d, line_cnt_q, line_cnt_d, last_lines_q, last_lines_d;
  logic [15:0] frame_data_q, frame_data_d, frame_cnt_q, frame_cnt_d;
  logic        data_en_q, data_en_d, new_en_q, new_en_d, err_q, err_d;
  logic        new_frame, err_set;

  always_ff @(posedge MT9D111_CLK or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_SKIP;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SKIP:   if (vs_rise && skip_cnt_q == SKIP_LIM) state_d = S_VBLANK;
      S_VBLANK: if (vs_fall) state_d = S_FRAME;
      S_FRAME:  if (vs_rise) state_d = S_VBLANK;
      default:  state_d = S_SKIP;
    endcase
  end

  always_comb begin
    new_frame    = vs_rise && ((state_q == S_SKIP && skip_cnt_q == SKIP_LIM) || state_q == S_FRAME);
    err_set      = 1'b0;
    skip_cnt_d   = skip_cnt_q;
    vcnt_d       = vcnt_q;
    hcnt_d       = hcnt_q;
    line_cnt_d   = line_cnt_q;
    last_lines_d = last_lines_q;
    frame_data_d = frame_data_q;
    frame_cnt_d  = frame_cnt_q;
    data_en_d    = 1'b0;
    new_en_d     = new_frame;
    if (state_q == S_SKIP && vs_rise) skip_cnt_d = skip_cnt_q + 4'd1;
    if (state_q == S_VBLANK && vs_fall) begin
      vcnt_d     = 11'd0;
      hcnt_d     = 11'd0;
      line_cnt_d = 11'd0;
    end
    if (state_q == S_FRAME) begin
      if (line_start) line_cnt_d = sat_inc(line_cnt_q);
      // a pixel landing on the VSYNC edge belongs to an aborted line
      if (pix_valid && !vs_rise) begin
        if (hcnt_q < H_LIM && vcnt_q < V_LIM) begin
          data_en_d    = 1'b1;
          frame_data_d = pix_data;
          hcnt_d       = hcnt_q + 11'd1;
        end else begin
          err_set = 1'b1;
        end
      end
      if (line_end) begin
        vcnt_d = sat_inc(vcnt_q);
        hcnt_d = 11'd0;
        if (half_pix) err_set = 1'b1;
      end
      if (vs_rise) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (href_lvl) err_set = 1'b1;
      end
    end
    if (new_frame) last_lines_d = line_cnt_d;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge MT9D111_CLK or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      skip_cnt_q   <= 4'd0;
      vcnt_q       <= 11'd0;
      hcnt_q       <= 11'd0;
      line_cnt_q   <= 11'd0;
      last_lines_q <= 11'd0;
      frame_data_q <= 16'd0;
      frame_cnt_q  <= 16'd0;
      data_en_q    <= 1'b0;
      new_en_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      skip_cnt_q   <= skip_cnt_d;
      vcnt_q       <= vcnt_d;
      hcnt_q       <= hcnt_d;
      line_cnt_q   <= line_cnt_d;
      last_lines_q <= last_lines_d;
      frame_data_q <= frame_data_d;
      frame_cnt_q  <= frame_cnt_d;
      data_en_q    <= data_en_d;
      new_en_q     <= new_en_d;
      err_q        <= err_d;
    end
  end

  assign MT9D111_FrameData   = frame_data_q;
  assign MT9D111_FrameDataEn = data_en_q;
  assign MT9D111_FrameHCnt   = hcnt_q;
  assign MT9D111_FrameVCnt   = vcnt_q;
  assign MT9D111_FrameNewEn  = new_en_q;
  assign cap_err             = err_q;
  assign cap_frame_cnt       = frame_cnt_q;
  assign last_frame_lines    = last_lines_q;

endmodule
`default_nettype wire

// File: tb/tb_mt9d111_frame_capture.sv
`default_nettype none
// tb_mt9d111_frame_capture: directed, table-driven bench for the MT9D111 capture stage (8x4 window, skip 2).
// Revision 1.0
module tb_mt9d111_frame_capture;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0, rst_n = 1'b0, vs = 1'b0, hr = 1'b0, err_clr = 1'b0;
  logic [7:0]  d = 8'd0;
  logic [15:0] fdata, fdata_sw, fcnt, fcnt_sw;
  logic        fen, fen_sw, fnew, fnew_sw, cerr, cerr_sw;
  logic [10:0] hc, hc_sw, vc, vc_sw, lfl, lfl_sw;

  always #5 clk = ~clk;

  mt9d111_frame_capture #(.CAM_H_WIDTH(H), .CAM_V_HEIGHT(V), .SKIP_FRAMES(2), .BYTE_SWAP(0)) dut (
    .MT9D111_CLK(clk), .sys_rst_n(rst_n), .MT9D111_VSYNC(vs), .MT9D111_HREF(hr), .MT9D111_D(d),
    .err_clr(err_clr), .MT9D111_FrameData(fdata), .MT9D111_FrameDataEn(fen), .MT9D111_FrameHCnt(hc),
    .MT9D111_FrameVCnt(vc), .MT9D111_FrameNewEn(fnew), .cap_err(cerr), .cap_frame_cnt(fcnt),
    .last_frame_lines(lfl));

  mt9d111_frame_capture #(.CAM_H_WIDTH(H), .CAM_V_HEIGHT(V), .SKIP_FRAMES(2), .BYTE_SWAP(1)) dut_sw (
    .MT9D111_CLK(clk), .sys_rst_n(rst_n), .MT9D111_VSYNC(vs), .MT9D111_HREF(hr), .MT9D111_D(d),
    .err_clr(err_clr), .MT9D111_FrameData(fdata_sw), .MT9D111_FrameDataEn(fen_sw), .MT9D111_FrameHCnt(hc_sw),
    .MT9D111_FrameVCnt(vc_sw), .MT9D111_FrameNewEn(fnew_sw), .cap_err(cerr_sw), .cap_frame_cnt(fcnt_sw),
    .last_frame_lines(lfl_sw));

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp_d;
    logic [15:0] exp_sw;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] exp_d;
    logic [15:0] exp_sw;
    logic [10:0] exp_h;
  } pend_t;

  vec_t  vec[8];
  pend_t pq[$];

  int n_cmp = 0, n_fail = 0;
  int tcnt = 0, strobes = 0, newens = 0, viol = 0, sw_diff = 0;
  int last_h = 0, last_v = 0, first_h = -1, first_v = -1;
  int s0 = 0, n0 = 0;
  logic prev_en = 1'b0, arm = 1'b0, strict = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Drive one sample edge, then observe outputs at the following falling edge.
  task automatic tick(input logic v, input logic h, input logic [7:0] b);
    pend_t e;
    vs = v; hr = h; d = b;
    @(negedge clk);
    tcnt++;
    if (fen) begin
      strobes++;
      last_h = int'(hc);
      last_v = int'(vc);
      if (arm) begin first_h = int'(hc); first_v = int'(vc); arm = 1'b0; end
    end
    if (fnew) newens++;
    if ((fen && prev_en) || (fen && fnew)) viol++;
    prev_en = fen;
    if ({fen, fnew, cerr, fcnt, lfl, hc, vc} !== {fen_sw, fnew_sw, cerr_sw, fcnt_sw, lfl_sw, hc_sw, vc_sw})
      sw_diff++;
    if (pq.size() > 0 && pq[0].due == tcnt) begin
      e = pq.pop_front();
      chk("tbl_en", fen, 1);
      chk("tbl_data", fdata, e.exp_d);
      chk("tbl_data_swap", fdata_sw, e.exp_sw);
      chk("tbl_hcnt", hc, e.exp_h);
      chk("tbl_vcnt", vc, 0);
    end else if (strict && fen) begin
      chk("stray_strobe", fen, 0);
    end
  endtask

  task automatic line(input int nbytes);
    for (int i = 0; i < nbytes; i++) tick(1'b0, 1'b1, 8'(i * 7 + 3));
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic vs_pulse(input logic exp_new);
    tick(1'b1, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 8'd0);
    chk("newen_early", fnew, 0);
    tick(1'b1, 1'b0, 8'd0);
    chk("newen_at_2", fnew, exp_new);
    tick(1'b1, 1'b0, 8'd0);
    chk("newen_one_cycle", fnew, 0);
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame(input int nlines, input int nbytes, input logic exp_new);
    vs_pulse(exp_new);
    repeat (nlines) line(nbytes);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1'b0, 1'b0, 8'd0);
    err_clr = 1'b0;
  endtask

  initial begin
    vec[0] = '{8'hF8, 8'h1F, 16'hF81F, 16'h1FF8};
    vec[1] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
    vec[2] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vec[3] = '{8'h12, 8'h34, 16'h1234, 16'h3412};
    vec[4] = '{8'hA5, 8'h5A, 16'hA55A, 16'h5AA5};
    vec[5] = '{8'h80, 8'h01, 16'h8001, 16'h0180};
    vec[6] = '{8'h07, 8'hE0, 16'h07E0, 16'hE007};
    vec[7] = '{8'hC3, 8'h3C, 16'hC33C, 16'h3CC3};

    // Reset state
    repeat (3) tick(1'b0, 1'b0, 8'd0);
    chk("rst_data", fdata, 0);
    chk("rst_en", fen, 0);
    chk("rst_hcnt", hc, 0);
    chk("rst_vcnt", vc, 0);
    chk("rst_newen", fnew, 0);
    chk("rst_err", cerr, 0);
    chk("rst_fcnt", fcnt, 0);
    chk("rst_lfl", lfl, 0);
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 8'd0);

    // Two settling frames are dropped, then frames 2 and 3 are forwarded
    s0 = strobes; n0 = newens;
    frame(V, 2 * H, 1'b0);
    frame(V, 2 * H, 1'b0);
    chk("skip_strobes", strobes - s0, 0);
    chk("skip_newen", newens - n0, 0);
    vs_pulse(1'b1);
    strict = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, vec[i].b0);
      tick(1'b0, 1'b1, vec[i].b1);
      pq.push_back('{due: tcnt + 2, exp_d: vec[i].exp_d, exp_sw: vec[i].exp_sw, exp_h: 11'(i + 1)});
    end
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    strict = 1'b0;
    chk("tbl_drained", pq.size(), 0);
    repeat (V - 1) line(2 * H);
    frame(V, 2 * H, 1'b1);
    vs_pulse(1'b1);
    chk("fwd_strobes", strobes - s0, 2 * H * V);
    chk("fwd_newen", newens - n0, 3);
    chk("fwd_fcnt", fcnt, 2);
    chk("fwd_err", cerr, 0);
    chk("fwd_lfl", lfl, V);

    // Odd byte count: full line of pixels, trailing half pixel flagged
    s0 = strobes;
    line(2 * H + 1);
    chk("odd_strobes", strobes - s0, H);
    chk("odd_last_h", last_h, H);
    chk("odd_err", cerr, 1);
    pulse_clr();
    chk("clr_err", cerr, 0);

    // Over-long line and over-tall frame are clipped to the window
    vs_pulse(1'b1);
    chk("odd_frame_lfl", lfl, 1);
    s0 = strobes;
    line(40);
    repeat (9) line(2 * H);
    chk("clip_strobes", strobes - s0, H * V);
    chk("clip_last_v", last_v, V - 1);
    chk("clip_last_h", last_h, H);
    chk("clip_vcnt", vc, 10);
    chk("clip_err", cerr, 1);
    vs_pulse(1'b1);
    chk("clip_lfl", lfl, 10);
    chk("clip_fcnt", fcnt, 4);
    pulse_clr();
    chk("clip_clr", cerr, 0);

    // VSYNC rising in the middle of a line
    line(2 * H);
    chk("abort_pre_vcnt", vc, 1);
    s0 = strobes; n0 = newens;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'(i + 1));
    repeat (4) tick(1'b1, 1'b1, 8'h55);
    repeat (4) tick(1'b1, 1'b0, 8'd0);
    chk("abort_strobes", strobes - s0, 3);
    chk("abort_newen", newens - n0, 1);
    chk("abort_vcnt", vc, 1);
    chk("abort_err", cerr, 1);
    chk("abort_fcnt", fcnt, 5);
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    arm = 1'b1;
    line(2 * H);
    chk("abort_next_h", first_h, 1);
    chk("abort_next_v", first_v, 0);

    // Asynchronous reset in the middle of a line
    repeat (5) tick(1'b0, 1'b1, 8'h9A);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_fcnt", fcnt, 0);
    chk("mid_rst_lfl", lfl, 0);
    chk("mid_rst_vcnt", vc, 0);
    chk("mid_rst_hcnt", hc, 0);
    chk("mid_rst_err", cerr, 0);
    chk("mid_rst_data", fdata, 0);
    repeat (2) tick(1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    s0 = strobes;
    frame(2, 2 * H, 1'b0);
    frame(2, 2 * H, 1'b0);
    chk("post_rst_skip", strobes - s0, 0);
    vs_pulse(1'b1);
    line(2 * H);
    chk("post_rst_fwd", strobes - s0, H);

    chk("no_back_to_back", viol, 0);
    chk("swap_inst_match", sw_diff, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
